// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
// pll_lock_supervisor
//   Supervises the PLL lock flag and sequences the PLL reset. Produces a
//   synchronously released active-low system reset for downstream logic.
//   Runs entirely on the free-running reference clock.
//
// Ports:
//   refclk       in   free-running reference clock
//   rst_n        in   asynchronous active-low reset
//   pll_locked   in   PLL lock flag, asynchronous to refclk
//   pll_rst      out  active-high PLL reset (PLL_RESET state only)
//   sys_rst_n    out  active-low downstream reset (released only in RUN)
//   ready        out  high only in RUN
//   relock_count out  saturating count of lock losses seen in RUN
//   err_timeout  out  sticky lock-timeout flag
//
// Build option:
//   PLL_LOCK_SUPERVISOR_TIMEOUT_EN - when defined, WAIT_LOCK re-resets the
//   PLL after LOCK_TIMEOUT_CYCLES and err_timeout is implemented. When not
//   defined, WAIT_LOCK waits forever and err_timeout is tied low.
module pll_lock_supervisor #(
  parameter int unsigned LOCK_SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1000,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_WIDTH           = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic       err_timeout
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] RstLast    = CNT_WIDTH'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] StableLast = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);

  state_e                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [LOCK_SYNC_STAGES-1:0] sync_q;
  logic                        lock_s;
  logic                        relock_inc;
  logic                        pll_rst_q, sys_rst_n_q, ready_q;
  logic [7:0]                  relock_q;

`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
  logic timeout_hit;
  logic err_q;
`endif

  assign lock_s = sync_q[LOCK_SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    relock_inc = 1'b0;
`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    unique case (state_q)
      PLL_RESET: begin
        if (cnt_q == RstLast) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a timeout falling on the same cycle.
        if (lock_s) begin
          state_d = STABILIZE;
        end
`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          state_d     = PLL_RESET;
          timeout_hit = 1'b1;
        end
`endif
      end
      STABILIZE: begin
        if (!lock_s)                 state_d = WAIT_LOCK;
        else if (cnt_q == StableLast) state_d = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          state_d    = PLL_RESET;
          relock_inc = 1'b1;
        end
      end
      default: state_d = PLL_RESET;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_WIDTH'(1);
  end

  // Outputs are decoded from the next state so they move on the same edge
  // as the state register while still coming straight from flops.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RESET;
      cnt_q       <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      relock_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= {sync_q[LOCK_SYNC_STAGES-2:0], pll_locked};
      pll_rst_q   <= (state_d == PLL_RESET);
      sys_rst_n_q <= (state_d == RUN);
      ready_q     <= (state_d == RUN);
      if (relock_inc && (relock_q != 8'hFF)) relock_q <= relock_q + 8'd1;
    end
  end

`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)           err_q <= 1'b0;
    else if (timeout_hit) err_q <= 1'b1;
  end
  assign err_timeout = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (LOCK_TIMEOUT_CYCLES == 0);
  assign err_timeout        = 1'b0;
`endif

  assign pll_rst      = pll_rst_q;
  assign sys_rst_n    = sys_rst_n_q;
  assign ready        = ready_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
`timescale 1ns/1ps
// Testbench for pll_lock_supervisor with LOCK_SYNC_STAGES=2, PLL_RST_CYCLES=4,
// LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64. Stimulus pushes expected
// output changes (edge index + output vector) into a queue; an independent
// monitor pops one entry every time the output vector changes.
module tb_pll_lock_supervisor;

  logic       refclk     = 1'b1;
  logic       rst_n      = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst_n, ready, err_timeout;
  logic [7:0] relock_count;

  pll_lock_supervisor #(
    .LOCK_SYNC_STAGES   (2),
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(64),
    .CNT_WIDTH          (20)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .relock_count(relock_count),
    .err_timeout (err_timeout)
  );

  always #5 refclk = ~refclk;

  // Number of rising edges seen so far; read only at falling edges.
  int unsigned cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int unsigned c;
    logic [11:0] v;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  // Output vector layout: {pll_rst, sys_rst_n, ready, err_timeout, relock_count}
  function automatic logic [11:0] vec(input logic p, input logic s, input logic r,
                                      input logic e, input logic [7:0] n);
    return {p, s, r, e, n};
  endfunction

  task automatic expect_ev(input int unsigned c, input logic [11:0] v);
    ev_t e;
    e.c = c;
    e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic to_cyc(input int unsigned t);
    while (cyc < t) @(negedge refclk);
  endtask

  // Monitor
  initial begin
    logic [11:0] prev, cur;
    bit          first;
    ev_t         e;
    first = 1'b1;
    prev  = '0;
    #2;
    forever begin
      @(negedge refclk or negedge rst_n);
      #1;
      cur = {pll_rst, sys_rst_n, ready, err_timeout, relock_count};
      if (first || (cur !== prev)) begin
        first = 1'b0;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change edge=%0d got=%b_%b_%b_%b_%0d required=no change",
                   cyc, cur[11], cur[10], cur[9], cur[8], cur[7:0]);
        end else begin
          e = exp_q.pop_front();
          if ((e.c != cyc) || (e.v !== cur)) begin
            bad++;
            $display("FAIL out_event got edge=%0d val=%b_%b_%b_%b_%0d required edge=%0d val=%b_%b_%b_%b_%0d",
                     cyc, cur[11], cur[10], cur[9], cur[8], cur[7:0],
                     e.c, e.v[11], e.v[10], e.v[9], e.v[8], e.v[7:0]);
          end
        end
        prev = cur;
      end
    end
  end

  // Stimulus
  initial begin
    int unsigned r, a, c;
    logic [7:0]  n;
    logic        to_en;
`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
    to_en = 1'b1;
`else
    to_en = 1'b0;
`endif

    // Reset, then lock after 10 unlocked cycles.
    #1 rst_n = 1'b0;
    expect_ev(0, vec(1, 0, 0, 0, 8'd0));
    to_cyc(2);
    expect_ev(6,  vec(0, 0, 0, 0, 8'd0));   // pll_rst high for edges 3..6
    expect_ev(23, vec(0, 1, 1, 0, 8'd0));   // first lock sample at edge 13, +10
    rst_n = 1'b1;
    to_cyc(12);
    pll_locked = 1'b1;

    // Repeated lock loss in RUN; relock_count saturates at 255.
    r = 23;
    for (int k = 1; k <= 300; k++) begin
      n = (k > 255) ? 8'd255 : 8'(k);
      to_cyc(r);
      expect_ev(r + 3,  vec(1, 0, 0, 0, n));
      expect_ev(r + 7,  vec(0, 0, 0, 0, n));
      expect_ev(r + 16, vec(0, 1, 1, 0, n));
      pll_locked = 1'b0;
      to_cyc(r + 3);
      pll_locked = 1'b1;
      r = r + 16;
    end

    // Lock lost and held low: timeout re-pulses (if built in), then lock returns.
    to_cyc(r);
    expect_ev(r + 3, vec(1, 0, 0, 0, 8'd255));
    expect_ev(r + 7, vec(0, 0, 0, 0, 8'd255));
`ifdef PLL_LOCK_SUPERVISOR_TIMEOUT_EN
    expect_ev(r + 71,  vec(1, 0, 0, 1, 8'd255));
    expect_ev(r + 75,  vec(0, 0, 0, 1, 8'd255));
    expect_ev(r + 139, vec(1, 0, 0, 1, 8'd255));
    expect_ev(r + 143, vec(0, 0, 0, 1, 8'd255));
`endif
    expect_ev(r + 161, vec(0, 1, 1, to_en, 8'd255));
    pll_locked = 1'b0;
    to_cyc(r + 150);
    pll_locked = 1'b1;

    // Asynchronous reset between edges while in RUN.
    to_cyc(r + 161);
    #7;
    c = cyc;
    expect_ev(c, vec(1, 0, 0, 0, 8'd0));
    rst_n = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b0;
    to_cyc(c + 2);
    a = cyc;
    expect_ev(a + 4,  vec(0, 0, 0, 0, 8'd0));
    expect_ev(a + 25, vec(0, 1, 1, 0, 8'd0));
    rst_n = 1'b1;

    // Lock chatter: 5 high, 3 low, then high; release needs 8 steady cycles.
    to_cyc(a + 6);
    pll_locked = 1'b1;
    to_cyc(a + 11);
    pll_locked = 1'b0;
    to_cyc(a + 14);
    pll_locked = 1'b1;
    to_cyc(a + 35);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events got=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish edge=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the PLL `locked` output, sequences the PLL's active-high reset, and produces a clean, synchronously released active-low system reset for downstream logic. It sits directly downstream of the PLL wrapper. It consumes `locked`, drives the PLL `rst` input, and issues a re-lock reset whenever lock is lost. It runs on the free-running reference clock, so it keeps operating while the PLL output clock is absent.

## Interface
Parameters:
- `LOCK_SYNC_STAGES`, default 2: synchronizer depth for `pll_locked`, valid range ≥2.
- `PLL_RST_CYCLES`, default 16: `pll_rst` pulse width in cycles, ≥1.
- `LOCK_STABLE_CYCLES`, default 1000: consecutive synchronized-lock cycles required before release, ≥1.
- `LOCK_TIMEOUT_CYCLES`, default 100000: cycles allowed in WAIT_LOCK before the PLL is re-reset, ≥1.
- `CNT_WIDTH`, default 20: shared counter width. Every cycle parameter must be < 2^CNT_WIDTH.

Ports:
- `refclk` in 1: reference clock, free-running.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `pll_locked` in 1: PLL lock flag, asynchronous to `refclk`.
- `pll_rst` out 1: active-high PLL reset.
- `sys_rst_n` out 1: active-low reset for downstream logic.
- `ready` out 1: high only in RUN.
- `relock_count` out 8: saturating count of lock losses in RUN.
- `err_timeout` out 1: sticky lock-timeout flag.

## Operation
- `pll_locked` passes through `LOCK_SYNC_STAGES` flops to become `lock_s`. All decisions use `lock_s` only.
- The FSM has four states: PLL_RESET, WAIT_LOCK, STABILIZE, RUN. One counter `cnt` is cleared on every state change.
- PLL_RESET:
  - `pll_rst`=1.
  - When `cnt`==`PLL_RST_CYCLES`-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_rst`=0.
  - If `lock_s`=1, go to STABILIZE.
  - Else if `cnt`==`LOCK_TIMEOUT_CYCLES`-1, set `err_timeout` and go to PLL_RESET.
  - Lock wins when both conditions hold in the same cycle.
- STABILIZE:
  - If `lock_s`=0, go to WAIT_LOCK.
  - Else if `cnt`==`LOCK_STABLE_CYCLES`-1, go to RUN.
- RUN:
  - If `lock_s`=0, go to PLL_RESET and increment `relock_count`, saturating at 255.
- Output decoding:
  - `sys_rst_n`=1 and `ready`=1 only in RUN.
  - `pll_rst`=1 only in PLL_RESET.
- All outputs are registered. They are decoded from the next state, so each output changes on the same edge as the state register.
- `err_timeout` and `relock_count` clear only on `rst_n`.

## Timing
- Reset values:
  - State is PLL_RESET and `cnt`=0.
  - Synchronizer flops are 0.
  - `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `relock_count`=0, `err_timeout`=0.
- When `rst_n` is asserted mid-operation, all registers return to reset values immediately and asynchronously. `sys_rst_n` falls without waiting for a clock edge.
- After `rst_n` deasserts, `pll_rst` stays high for exactly `PLL_RST_CYCLES` edges.
- Lock acquisition: let edge e0 be the first to sample `pll_locked`=1 while in WAIT_LOCK. If lock holds, STABILIZE is entered at e0+`LOCK_SYNC_STAGES` and `sys_rst_n`/`ready` rise at e0+`LOCK_SYNC_STAGES`+`LOCK_STABLE_CYCLES`.
- Lock loss in RUN: let e0 be the first edge that samples `pll_locked`=0. At e0+`LOCK_SYNC_STAGES`, `sys_rst_n` falls, `ready` falls and `pll_rst` rises, all on the same edge.
- Glitches: a low pulse on `pll_locked` shorter than one `refclk` period may be missed. Any pulse held across at least 2 edges must be acted on.
- `sys_rst_n` deassertion is always synchronous to `refclk`. Assertion is either synchronous (lock loss) or asynchronous (`rst_n`).

## Configuration
- `PLL_LOCK_SUPERVISOR_TIMEOUT_EN` defined:
  - The WAIT_LOCK timeout path and `err_timeout` are implemented as described above.
- Not defined:
  - WAIT_LOCK waits indefinitely for lock.
  - `err_timeout` is tied to 0.
  - `LOCK_TIMEOUT_CYCLES` is ignored.

## Test plan
Bench parameters: `LOCK_SYNC_STAGES`=2, `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=64.
- Reset then lock: release `rst_n`, hold `pll_locked`=0 for 10 cycles, then 1 → `pll_rst` high for exactly 4 cycles, and `sys_rst_n`/`ready` rise 10 edges after the first edge that samples lock.
- Lock chatter: raise `pll_locked`, drop it for 3 cycles after 5 cycles, raise it again → no release until 8 consecutive synchronized-high cycles; `relock_count` stays 0.
- Lock loss in RUN: drop `pll_locked` → `sys_rst_n` falls and `pll_rst` rises exactly 2 edges later, `pll_rst` pulses 4 cycles, `relock_count`=1. Repeat 300 times → `relock_count` saturates at 255.
- Timeout, macro defined: keep `pll_locked`=0 → `pll_rst` re-pulses every 4+64 cycles and `err_timeout` goes high and stays high after a later lock. Macro undefined → no re-pulse and `err_timeout`=0.
- Async reset in RUN: assert `rst_n` between clock edges → `sys_rst_n` and `ready` fall and `pll_rst` rises with no clock edge; `relock_count` and `err_timeout` clear to 0.
